// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: DEPTH-entry circular buffer of
// {pc, inst, fault}, first-word-fall-through, cleared by flush or reset.
module inst_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned INST_W = 32
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [ADDR_W-1:0]        in_pc,
  input  logic [INST_W-1:0]        in_inst,
  input  logic                     in_fault,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [INST_W-1:0]        out_inst,
  output logic                     out_fault,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_q    [DEPTH];
  logic [INST_W-1:0] inst_q  [DEPTH];
  logic              fault_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

  always_comb begin
    in_ready  = !reset && !flush && (count != CNT_W'(DEPTH));
    out_valid = !reset && (count != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    // Empty (or in-reset) queue presents a NOP so stale storage never leaks out.
    out_pc    = out_valid ? pc_q[rd_ptr]    : '0;
    out_inst  = out_valid ? inst_q[rd_ptr]  : INST_W'(32'h0000_0013);
    out_fault = out_valid ? fault_q[rd_ptr] : 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      pc_q[wr_ptr]   <= in_pc;
      inst_q[wr_ptr] <= in_inst;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) fault_q[i] <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fault_q[wr_ptr] <= in_fault;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue with hand-computed expectations.
module tb_inst_queue;

  logic        CLK = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [63:0] in_pc;
  logic [31:0] in_inst;
  logic        in_fault;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_fault;
  logic        out_ready;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  inst_queue #(.DEPTH(4), .ADDR_W(64), .INST_W(32)) dut (
    .CLK(CLK), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_fault(in_fault),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_fault(out_fault),
    .out_ready(out_ready), .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the edge; checks happen 1ns later, well before the next edge.
  task automatic settle();
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic f, input logic rdy);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = 32'hA500_0000 | pc[31:0];
    in_fault  = f;
    out_ready = rdy;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    drive(1'b0, 64'h0, 1'b0, 1'b0);

    // Reset held for two cycles, then idle.
    tick(); settle();
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    tick();
    reset = 1'b0; settle();
    check_eq("idle_in_ready", in_ready, 1);
    check_eq("idle_out_valid", out_valid, 0);
    check_eq("idle_count", count, 0);
    check_eq("idle_out_inst", out_inst, 32'h0000_0013);
    check_eq("idle_out_pc", out_pc, 0);

    // Fill to full, attempt a fifth push, then drain in order.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h1000 + 64'(4 * i), 1'b0, 1'b0); settle();
      check_eq("fill_in_ready", in_ready, 1);
      tick();
    end
    drive(1'b1, 64'h1010, 1'b0, 1'b0); settle();
    check_eq("full_count", count, 4);
    check_eq("full_in_ready", in_ready, 0);
    tick();
    check_eq("full_no_5th", count, 4);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 64'h0, 1'b0, 1'b1); settle();
      check_eq("drain_valid", out_valid, 1);
      check_eq("drain_pc", out_pc, 64'h1000 + 64'(4 * i));
      check_eq("drain_inst", out_inst, 32'hA500_1000 + 32'(4 * i));
      tick();
    end
    drive(1'b0, 64'h0, 1'b0, 1'b0); settle();
    check_eq("drained_count", count, 0);
    check_eq("drained_valid", out_valid, 0);

    // Streaming at count=1 for 20 cycles; pointers wrap several times.
    drive(1'b1, 64'h4000, 1'b0, 1'b0); settle();
    tick();
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 64'h4004 + 64'(4 * k), 1'b0, 1'b1); settle();
      check_eq("stream_count", count, 1);
      check_eq("stream_pc", out_pc, 64'h4000 + 64'(4 * k));
      tick();
    end
    drive(1'b0, 64'h0, 1'b0, 1'b1); settle();
    check_eq("stream_last_pc", out_pc, 64'h4050);
    tick();
    drive(1'b0, 64'h0, 1'b0, 1'b0); settle();
    check_eq("stream_end_count", count, 0);

    // Flush with three entries and a concurrent in_valid.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h5000 + 64'(4 * i), 1'b0, 1'b0); settle();
      tick();
    end
    flush = 1'b1;
    drive(1'b1, 64'h5FF0, 1'b0, 1'b0); settle();
    check_eq("flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    drive(1'b1, 64'h2000, 1'b0, 1'b0); settle();
    check_eq("postflush_count", count, 0);
    check_eq("postflush_valid", out_valid, 0);
    check_eq("postflush_in_ready", in_ready, 1);
    check_eq("postflush_pc", out_pc, 0);
    tick();
    drive(1'b0, 64'h0, 1'b0, 1'b1); settle();
    check_eq("flush_push_valid", out_valid, 1);
    check_eq("flush_push_pc", out_pc, 64'h2000);
    check_eq("flush_push_count", count, 1);
    tick();
    drive(1'b0, 64'h0, 1'b0, 1'b0); settle();
    check_eq("flush_drained", count, 0);

    // Fault bit travels with its PC.
    drive(1'b1, 64'h3000, 1'b1, 1'b0); settle(); tick();
    drive(1'b1, 64'h3004, 1'b0, 1'b0); settle(); tick();
    drive(1'b0, 64'h0, 1'b0, 1'b1); settle();
    check_eq("fault0_pc", out_pc, 64'h3000);
    check_eq("fault0_bit", out_fault, 1);
    tick();
    check_eq("fault1_pc", out_pc, 64'h3004);
    check_eq("fault1_bit", out_fault, 0);
    tick();
    drive(1'b0, 64'h0, 1'b0, 1'b0); settle();
    check_eq("fault_drained", count, 0);

    // Reset mid-operation with two entries and an active push.
    drive(1'b1, 64'h6000, 1'b0, 1'b0); settle(); tick();
    drive(1'b1, 64'h6004, 1'b0, 1'b0); settle(); tick();
    reset = 1'b1;
    drive(1'b1, 64'h6008, 1'b0, 1'b0); settle();
    check_eq("midrst_count_before", count, 2);
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_in_ready", in_ready, 0);
    check_eq("midrst_out_pc", out_pc, 0);
    tick();
    reset = 1'b0;
    drive(1'b0, 64'h0, 1'b0, 1'b1); settle();
    check_eq("midrst_count", count, 0);
    check_eq("midrst_valid_after", out_valid, 0);
    check_eq("midrst_pc_after", out_pc, 0);
    drive(1'b1, 64'h7000, 1'b0, 1'b0); settle(); tick();
    drive(1'b0, 64'h0, 1'b0, 1'b1); settle();
    check_eq("midrst_new_pc", out_pc, 64'h7000);
    check_eq("midrst_new_count", count, 1);
    tick();
    drive(1'b0, 64'h0, 1'b0, 1'b0); settle();
    check_eq("midrst_final_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
